// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller slice.
// Holds stage geometry defaults, bubble payload values and the FSM state encoding.
package pipe_ctrl_pkg;

    localparam int NSTAGES_DEF   = 10;
    localparam int RA_IDX_DEF    = 5;
    localparam int EX_IDX_DEF    = 7;
    localparam int FETCH_LAT_DEF = 1;

    // Payload a bubbled latch loads instead of its upstream stage
    localparam logic [11:0] PIPE_NOP  = 12'h000;
    localparam logic [3:0]  ISET_BASE = 4'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Event inputs and latch-control outputs between the pipeline and its controller.
// The master side raises pipeline events; the slave side is the controller.
interface pipe_ctrl_if #(
    parameter int NSTAGES = 10
);
    logic               raw_hazard;
    logic               mem_busy;
    logic               branch_taken;
    logic [11:0]        branch_pc;
    logic [3:0]         branch_iset;
    logic               halt_req;
    logic               resume_req;
    logic [NSTAGES-1:0] stage_en;
    logic [NSTAGES-1:0] stage_bubble;
    logic               redir_valid;
    logic [11:0]        redir_pc;
    logic [3:0]         redir_iset;
    logic               halted;
    logic [15:0]        stall_cnt;
    logic [15:0]        flush_cnt;

    modport master (
        output raw_hazard, mem_busy, branch_taken, branch_pc, branch_iset,
               halt_req, resume_req,
        input  stage_en, stage_bubble, redir_valid, redir_pc, redir_iset,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  raw_hazard, mem_busy, branch_taken, branch_pc, branch_iset,
               halt_req, resume_req,
        output stage_en, stage_bubble, redir_valid, redir_pc, redir_iset,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sat_cnt16.sv
// 16-bit event counter with enable and synchronous clear that sticks at 16'hFFFF.
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= 16'h0000;
        else if (clear)
            count <= 16'h0000;
        else if (en && (count != 16'hFFFF))
            count <= count + 16'd1;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-latch load enables and bubble selects from hazard, memory,
// branch and halt events, plus fetch redirect and stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGES   = NSTAGES_DEF,
    parameter int RA_IDX    = RA_IDX_DEF,
    parameter int EX_IDX    = EX_IDX_DEF,
    parameter int FETCH_LAT = FETCH_LAT_DEF
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    state_t             state;
    state_t             state_next;
    logic [2:0]         shadow;
    logic [2:0]         shadow_next;
    logic [NSTAGES-1:0] en_c;
    logic [NSTAGES-1:0] bubble_c;
    logic               redir_c;
    logic [NSTAGES-1:0] ra_mask;
    logic [NSTAGES-1:0] ex_mask;
    logic [NSTAGES-1:0] ra_bit;
    logic               stall_inc;

    // Latches upstream of RA freeze on a RAW stall; latches upstream of EX are squashed on a branch
    for (genvar i = 0; i < NSTAGES; i++) begin : g_mask
        assign ra_mask[i] = (i < RA_IDX);
        assign ex_mask[i] = (i < EX_IDX);
        assign ra_bit[i]  = (i == RA_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            shadow <= 3'd0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
        end
    end

    always_comb begin
        state_next  = state;
        shadow_next = shadow;
        en_c        = '0;
        bubble_c    = '0;
        redir_c     = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (bus.halt_req && !bus.mem_busy)
                        state_next = HALT;
                    if (bus.mem_busy) begin
                        en_c = '0;
                    end else if (bus.branch_taken) begin
                        redir_c     = 1'b1;
                        en_c        = '1;
                        bubble_c    = ex_mask;
                        shadow_next = 3'(FETCH_LAT);
                    end else if (bus.raw_hazard) begin
                        en_c     = ~ra_mask;
                        bubble_c = ra_bit;
                    end else if (shadow != 3'd0) begin
                        en_c        = '1;
                        bubble_c[0] = 1'b1;
                        shadow_next = shadow - 3'd1;
                    end else begin
                        en_c = '1;
                    end
                end
                HALT: begin
                    if (bus.resume_req)
                        state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    assign stall_inc = ~(&en_c);

    assign bus.stage_en     = en_c;
    assign bus.stage_bubble = bubble_c;
    assign bus.redir_valid  = redir_c;
    assign bus.redir_pc     = bus.branch_pc;
    assign bus.redir_iset   = bus.branch_iset;
    assign bus.halted       = (state == HALT);

    sat_cnt16 u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (stall_inc),
        .count (bus.stall_cnt)
    );

    sat_cnt16 u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .en    (redir_c),
        .count (bus.flush_cnt)
    );

endmodule
